tpu_tile_sequencer: RTL and testbench
=====================================

// Module: tpu_tile_sequencer
// PURPOSE
//  Parametrised controller for the TPU datapath; replaces the fixed 16x16 start/counter sequencing.
//  Runs NUM_TILES weight tiles back-to-back. For each tile it:
//   - pops the weight FIFO and pulses we_rl;
//   - streams MATRIX_SIZE activation rows from the unified buffer;
//   - writes the MATRIX_SIZE de-skewed result rows to result SRAM after a fixed pipe latency.
//  Sits between the host/start logic and the SRAM_UB / Weight_FIFO / systolic array / SRAM_Results.
// PARAMETERS
//  ADDRESSSIZE  10                   UB and result SRAM address width
//  MATRIX_SIZE  16                   array dimension = rows streamed and written per tile
//  TILE_BW      8                    width of the tile-count field
//  LATENCY      2*MATRIX_SIZE+2      cycles from ub_re of a row to res_we of that row (UB read + skew + array + de-skew)
// PORTS
//  clk             in   1            clock
//  rst             in   1            asynchronous active-high reset
//  start           in   1            1-cycle pulse; sampled only in IDLE
//  num_tiles       in   TILE_BW      tiles to run; latched on start
//  ub_base         in   ADDRESSSIZE  first UB row address; latched on start
//  res_base        in   ADDRESSSIZE  first result row address; latched on start
//  fifo_empty      in   1            weight FIFO empty
//  fifo_rd_en      out  1            weight FIFO pop
//  we_rl           out  1            weight reload pulse to the systolic array
//  ub_re           out  1            UB row read strobe
//  ub_addr         out  ADDRESSSIZE  UB row address
//  res_we          out  1            result SRAM write enable
//  res_addr        out  ADDRESSSIZE  result SRAM address
//  busy            out  1            high from the cycle after an accepted start until done
//  done            out  1            1-cycle pulse when the job completes
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, delay line cleared. Reset asserted mid-job aborts immediately, with no done pulse.
//  States: IDLE -> LOAD_W -> RELOAD -> STREAM -> DRAIN -> (LOAD_W | FINISH) -> IDLE.
//  IDLE
//   - start=1: latch inputs; tile_cnt=0; go to LOAD_W.
//   - start=1 with num_tiles==0: go to FINISH instead.
//  LOAD_W
//   - Hold while fifo_empty=1.
//   - Else assert fifo_rd_en for exactly 1 cycle and go to RELOAD.
//  RELOAD: we_rl=1 for 1 cycle (FIFO data valid one cycle after pop); row_cnt=0; go to STREAM.
//  STREAM
//   - Each cycle: ub_re=1, ub_addr = ub_base + tile_cnt*MATRIX_SIZE + row_cnt.
//   - After MATRIX_SIZE cycles go to DRAIN.
//  Result writes
//   - ub_re feeds a LATENCY-deep 1-bit delay line; res_we = delay-line output.
//   - res_addr starts at res_base and increments by 1 after every res_we.
//   - Row r of tile t is written at res_base + t*MATRIX_SIZE + r.
//  DRAIN
//   - Wait until the delay line is empty, i.e. the last res_we of the tile has issued.
//   - Then tile_cnt++; go to LOAD_W if tile_cnt < num_tiles, else FINISH.
//   - Tiles never overlap, because we_rl would corrupt in-flight partial sums.
//  FINISH: done=1 for 1 cycle, busy=0; go to IDLE.
//  start while busy: ignored (no restart, no queueing).
//  Address arithmetic is modulo 2^ADDRESSSIZE; wrap-around is silent.
//  fifo_empty rising mid-job: takes effect only in LOAD_W; STREAM/DRAIN never stall.
//  Per-tile latency with a non-empty FIFO: 2 + MATRIX_SIZE + LATENCY cycles.
// CONFIGURATION
//  TPU_SEQ_PERF_EN defined:
//   - Adds output perf_cycles [31:0], cleared on accepted start.
//   - Increments every busy cycle; saturates at 2^32-1.
//   - Also counts stall cycles (LOAD_W with fifo_empty=1) in perf_stalls [31:0].
//   - Both hold their value in IDLE.
//  TPU_SEQ_PERF_EN undefined: these ports and counters do not exist.
// STRUCTURE
//  Package tpu_pkg:
//   - state encoding localparams ST_IDLE..ST_FINISH;
//   - the default LATENCY formula as a function of MATRIX_SIZE.
//  Sub-module sig_delay_line #(DEPTH, WIDTH):
//   - clocked shift register with async active-high clear;
//   - also exposes an any-bit-set flag used as "pipe not empty".
// TESTING
//  1. num_tiles=1, ub_base=0, res_base=0, FIFO non-empty:
//     - fifo_rd_en at cycle 1, we_rl at cycle 2, ub_re at cycles 3..18;
//     - res_we at cycles 37..52 with res_addr 0..15; done at cycle 53.
//  2. num_tiles=3, ub_base=0x3F8:
//     - ub_addr wraps 0x3FF -> 0x000;
//     - 48 res_we total, res_addr 0..47; single done.
//  3. num_tiles=0: done exactly 2 cycles after start; no fifo_rd_en/ub_re/res_we ever asserted.
//  4. fifo_empty=1 for 10 cycles at tile 2's LOAD_W:
//     - tile 2 ub_re starts exactly 10 cycles later than in the unstalled run;
//     - PERF build: perf_stalls=10.
//  5. start pulsed mid-STREAM: ignored; address sequence identical to the reference run.
//  6. rst asserted during DRAIN:
//     - all outputs 0 in the same cycle; no done pulse;
//     - a fresh start then behaves as in test 1.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared state encoding and latency helper for the TPU tile sequencer
// Purpose: FSM state codes for tpu_tile_sequencer and the default row pipe latency.
// Ports: none (package).
package tpu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_RELOAD = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD_W = ST_LOAD_W,
    S_RELOAD = ST_RELOAD,
    S_STREAM = ST_STREAM,
    S_DRAIN  = ST_DRAIN,
    S_FINISH = ST_FINISH
  } seq_state_e;

  // UB read (1) + input skew + array traversal (2*N) + output de-skew (1).
  function automatic int default_latency(input int matrix_size);
    return 2 * matrix_size + 2;
  endfunction

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// rtl/tpu_tile_sequencer_if.sv - host, weight FIFO, UB and result SRAM signals of the tile sequencer
// Purpose: bundles every non-clock port of tpu_tile_sequencer.
// Modports: master = sequencer side, slave = surrounding datapath/host side.
// Optional: TPU_SEQ_PERF_EN adds perf_cycles / perf_stalls.
interface tpu_tile_sequencer_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int TILE_BW     = 8
);
  logic                   start;
  logic [TILE_BW-1:0]     num_tiles;
  logic [ADDRESSSIZE-1:0] ub_base;
  logic [ADDRESSSIZE-1:0] res_base;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic                   we_rl;
  logic                   ub_re;
  logic [ADDRESSSIZE-1:0] ub_addr;
  logic                   res_we;
  logic [ADDRESSSIZE-1:0] res_addr;
  logic                   busy;
  logic                   done;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0]            perf_cycles;
  logic [31:0]            perf_stalls;
`endif

  modport master (
    input  start, num_tiles, ub_base, res_base, fifo_empty,
    output fifo_rd_en, we_rl, ub_re, ub_addr, res_we, res_addr, busy, done
`ifdef TPU_SEQ_PERF_EN
    , output perf_cycles, perf_stalls
`endif
  );

  modport slave (
    output start, num_tiles, ub_base, res_base, fifo_empty,
    input  fifo_rd_en, we_rl, ub_re, ub_addr, res_we, res_addr, busy, done
`ifdef TPU_SEQ_PERF_EN
    , input perf_cycles, perf_stalls
`endif
  );

endinterface

// File: rtl/sig_delay_line.sv
// rtl/sig_delay_line.sv - fixed-depth shift register with async clear and occupancy flag
// Purpose: delays din by DEPTH cycles; any_set is high while any stage holds a set bit.
// Ports: clk, rst (async active-high clear), din/dout [WIDTH], any_set.
module sig_delay_line #(
  parameter int DEPTH = 33,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_set
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_comb begin
    any_set = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_set = any_set | (|stage_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/tpu_tile_sequencer.sv
// rtl/tpu_tile_sequencer.sv - runs NUM_TILES weight tiles through the systolic array back-to-back
// Purpose: per tile pops the weight FIFO, pulses we_rl, streams MATRIX_SIZE UB rows and
//          writes the MATRIX_SIZE result rows LATENCY cycles after each row read.
// Ports: clk, rst (async active-high), bus (tpu_tile_sequencer_if.master):
//        start/num_tiles/ub_base/res_base/fifo_empty in; fifo_rd_en/we_rl/ub_re/ub_addr/
//        res_we/res_addr/busy/done out.
// Optional: TPU_SEQ_PERF_EN adds perf_cycles (busy cycles) and perf_stalls (LOAD_W starved cycles).
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 16,
  parameter int TILE_BW     = 8,
  parameter int LATENCY     = default_latency(MATRIX_SIZE)
) (
  input  logic clk,
  input  logic rst,
  tpu_tile_sequencer_if.master bus
);

  localparam int ROW_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_SIZE - 1);

  seq_state_e             state_q, state_d;
  logic [TILE_BW-1:0]     num_tiles_q, num_tiles_d;
  logic [TILE_BW-1:0]     tile_cnt_q, tile_cnt_d;
  logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
  logic                   we_rl_q, we_rl_d;
  logic                   ub_re_q, ub_re_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
  logic                   res_we_q, res_we_d;
  logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [TILE_BW:0]       tile_next;
  logic                   pipe_out, pipe_any, start_acc, fifo_pop;

  // res_we_q is the final stage of the LATENCY-deep row pipe, so the line itself is one shorter.
  sig_delay_line #(.DEPTH(LATENCY - 1), .WIDTH(1)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .din     (ub_re_q),
    .dout    (pipe_out),
    .any_set (pipe_any)
  );

  assign start_acc = (state_q == S_IDLE) && bus.start;
  // Pop decided on the live empty flag so a ready FIFO costs no extra cycle.
  assign fifo_pop  = (state_q == S_LOAD_W) && !bus.fifo_empty;

  always_comb begin
    state_d     = state_q;
    num_tiles_d = num_tiles_q;
    tile_cnt_d  = tile_cnt_q;
    row_cnt_d   = row_cnt_q;
    we_rl_d     = 1'b0;
    ub_re_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tile_next   = {1'b0, tile_cnt_q} + 1'b1;
    res_we_d    = pipe_out;
    // Both pointers advance after each strobe; rows are contiguous across tiles.
    ub_addr_d   = ub_re_q  ? ub_addr_q + 1'b1  : ub_addr_q;
    res_addr_d  = res_we_q ? res_addr_q + 1'b1 : res_addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_tiles_d = bus.num_tiles;
          tile_cnt_d  = '0;
          ub_addr_d   = bus.ub_base;
          res_addr_d  = bus.res_base;
          busy_d      = 1'b1;
          // A zero-tile job passes through DRAIN, whose empty pipe sends it to FINISH.
          state_d     = (bus.num_tiles == '0) ? S_DRAIN : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (fifo_pop) begin
          we_rl_d = 1'b1;
          state_d = S_RELOAD;
        end
      end
      S_RELOAD: begin
        row_cnt_d = '0;
        ub_re_d   = 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (row_cnt_q == ROW_LAST) begin
          state_d = S_DRAIN;
        end else begin
          ub_re_d   = 1'b1;
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Line empty: the tile's last row is in res_we_q and issues this cycle.
        if (!pipe_any) begin
          tile_cnt_d = tile_next[TILE_BW-1:0];
          if (tile_next < {1'b0, num_tiles_q}) begin
            state_d = S_LOAD_W;
          end else begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_tiles_q <= '0;
      tile_cnt_q  <= '0;
      row_cnt_q   <= '0;
      we_rl_q     <= 1'b0;
      ub_re_q     <= 1'b0;
      ub_addr_q   <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_tiles_q <= num_tiles_d;
      tile_cnt_q  <= tile_cnt_d;
      row_cnt_q   <= row_cnt_d;
      we_rl_q     <= we_rl_d;
      ub_re_q     <= ub_re_d;
      ub_addr_q   <= ub_addr_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.fifo_rd_en = fifo_pop;
  assign bus.we_rl      = we_rl_q;
  assign bus.ub_re      = ub_re_q;
  assign bus.ub_addr    = ub_addr_q;
  assign bus.res_we     = res_we_q;
  assign bus.res_addr   = res_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (start_acc) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == S_LOAD_W) && bus.fifo_empty && (perf_stalls_q != '1))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb/tb_tpu_tile_sequencer.sv - scoreboard bench for tpu_tile_sequencer
module tb_tpu_tile_sequencer;

  localparam int A    = 10;
  localparam int M    = 16;
  localparam int L    = 2 * M + 2;
  localparam int AMOD = 1 << A;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;

  int q_pop[$];
  int q_rl[$];
  int q_ub_c[$];
  int q_ub_a[$];
  int q_res_c[$];
  int q_res_a[$];
  int q_done[$];
  bit force_empty[int];
  bit force_ok[int];

  tpu_tile_sequencer_if #(.ADDRESSSIZE(A), .TILE_BW(8)) bus ();

  tpu_tile_sequencer #(
    .ADDRESSSIZE (A),
    .MATRIX_SIZE (M),
    .TILE_BW     (8),
    .LATENCY     (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every strobe the DUT presents is matched against the oldest expected event.
  always @(negedge clk) begin
    if (bus.fifo_rd_en) begin
      if (q_pop.size() == 0) chk("fifo_rd_en_unexpected", 1, 0);
      else chk("fifo_rd_en_cycle", cyc, q_pop.pop_front());
    end
    if (bus.we_rl) begin
      if (q_rl.size() == 0) chk("we_rl_unexpected", 1, 0);
      else chk("we_rl_cycle", cyc, q_rl.pop_front());
    end
    if (bus.ub_re) begin
      if (q_ub_c.size() == 0) chk("ub_re_unexpected", 1, 0);
      else begin
        chk("ub_re_cycle", cyc, q_ub_c.pop_front());
        chk("ub_addr", bus.ub_addr, q_ub_a.pop_front());
      end
    end
    if (bus.res_we) begin
      if (q_res_c.size() == 0) chk("res_we_unexpected", 1, 0);
      else begin
        chk("res_we_cycle", cyc, q_res_c.pop_front());
        chk("res_addr", bus.res_addr, q_res_a.pop_front());
      end
    end
    if (bus.done) begin
      if (q_done.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc, q_done.pop_front());
    end
    chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (force_empty.exists(cyc))   bus.fifo_empty = 1'b1;
    else if (force_ok.exists(cyc)) bus.fifo_empty = 1'b0;
    else                           bus.fifo_empty = 1'($urandom_range(0, 1));
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_fifo_rd_en"}, bus.fifo_rd_en, 0);
    chk({tag, "_we_rl"},      bus.we_rl, 0);
    chk({tag, "_ub_re"},      bus.ub_re, 0);
    chk({tag, "_ub_addr"},    bus.ub_addr, 0);
    chk({tag, "_res_we"},     bus.res_we, 0);
    chk({tag, "_res_addr"},   bus.res_addr, 0);
    chk({tag, "_busy"},       bus.busy, 0);
    chk({tag, "_done"},       bus.done, 0);
  endtask

  task automatic do_abort();
    q_pop.delete(); q_rl.delete(); q_ub_c.delete(); q_ub_a.delete();
    q_res_c.delete(); q_res_a.delete(); q_done.delete();
    busy_lo = 1;
    busy_hi = 0;
    rst = 1'b1;
    #1;
    check_zero("abort");
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Reference model: tile t pops at the first FIFO-ready LOAD_W cycle, reloads next cycle,
  // reads rows over the following M cycles, writes each row L cycles after its read,
  // and the next tile's LOAD_W follows the tile's last write.
  task automatic run_job(int nt, int ubb, int resb, int stall_t, int stall_n,
                         bit mid_start, int abort_off);
    int s, c, pop, done_c, exp_stalls;
    bit aborted;
    s = cyc;
    c = s + 1;
    exp_stalls = 0;
    aborted = 1'b0;
    for (int t = 0; t < nt; t++) begin
      if (t == stall_t) begin
        for (int k = 0; k < stall_n; k++) force_empty[c + k] = 1'b1;
        pop = c + stall_n;
        exp_stalls = stall_n;
      end else begin
        pop = c;
      end
      force_ok[pop] = 1'b1;
      q_pop.push_back(pop);
      q_rl.push_back(pop + 1);
      for (int r = 0; r < M; r++) begin
        q_ub_c.push_back(pop + 2 + r);
        q_ub_a.push_back((ubb + t * M + r) % AMOD);
        q_res_c.push_back(pop + 2 + L + r);
        q_res_a.push_back((resb + t * M + r) % AMOD);
      end
      c = pop + 2 + M + L;
    end
    done_c = (nt == 0) ? s + 2 : c;
    q_done.push_back(done_c);
    busy_lo = s + 1;
    busy_hi = done_c - 1;

    bus.start     = 1'b1;
    bus.num_tiles = 8'(nt);
    bus.ub_base   = A'(ubb);
    bus.res_base  = A'(resb);
    tick();
    while (cyc < done_c + 2 && !aborted) begin
      bus.start = 1'b0;
      bus.num_tiles = 8'($urandom);
      bus.ub_base   = A'($urandom);
      bus.res_base  = A'($urandom);
      if (mid_start && cyc == s + 8) begin
        bus.start     = 1'b1;
        bus.num_tiles = 8'($urandom_range(1, 5));
      end
      if (abort_off != 0 && cyc == s + abort_off) begin
        do_abort();
        aborted = 1'b1;
      end else begin
        tick();
      end
    end
    bus.start = 1'b0;
    if (!aborted) begin
      chk("left_fifo_rd_en", q_pop.size(), 0);
      chk("left_we_rl",      q_rl.size(), 0);
      chk("left_ub_re",      q_ub_c.size(), 0);
      chk("left_res_we",     q_res_c.size(), 0);
      chk("left_done",       q_done.size(), 0);
`ifdef TPU_SEQ_PERF_EN
      chk("perf_cycles", bus.perf_cycles, done_c - s - 1);
      chk("perf_stalls", bus.perf_stalls, exp_stalls);
`else
      if (exp_stalls < 0) chk("stall_model", exp_stalls, 0);
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start      = 1'b0;
    bus.num_tiles  = '0;
    bus.ub_base    = '0;
    bus.res_base   = '0;
    bus.fifo_empty = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("idle");

    run_job(1, 0,      0,      -1, 0,  1'b0, 0);   // single tile timing
    run_job(3, 'h3F8,  0,      -1, 0,  1'b0, 0);   // UB address wrap
    run_job(0, 5,      7,      -1, 0,  1'b0, 0);   // zero tiles
    run_job(3, 'h20,   'h40,    1, 10, 1'b0, 0);   // 10-cycle stall at tile 2
    run_job(2, 'h11,   'h22,   -1, 0,  1'b1, 0);   // start while busy
    run_job(1, 0,      'h100,  -1, 0,  1'b0, 30);  // reset during DRAIN
    run_job(1, 0,      0,      -1, 0,  1'b0, 0);   // fresh start after reset
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 3), $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
              $urandom_range(0, 3), $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
